mem_port_arbiter: RTL

Two-master arbiter and sequencer for the single-port instruction/data memory (10-bit word address, 32-bit data). Master 0 is the multi-cycle CPU path: its `m0_ready` drives the CPU's `MIO_ready` stall input. Master 1 is a secondary requester, such as a program loader or debug/DMA port. The block owns the memory's `wea`/`addra`/`dina` pins, serialises accesses, and returns read data with a one-cycle ready pulse per transaction.

---
 rtl/mem_port_arbiter_if.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the two requester ports and the memory pins of mem_port_arbiter.
//   m0_*/m1_* : req, we, addr, wdata from each requester; rdata, ready back
//   mem_*     : we, addr, din toward the memory; dout from the memory
//   owner     : current grant (00 none, 01 master 0, 10 master 1)
// Modports:
//   slave  - the arbiter side
//   master - the requester side (both masters plus the owner indication)
//   memory - the memory side
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ready;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ready;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  logic [1:0]        owner;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_rdata, m0_ready,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_rdata, m1_ready,
    output mem_we, mem_addr, mem_din,
    input  mem_dout,
    output owner
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_rdata, m0_ready,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_rdata, m1_ready,
    input  owner
  );

  modport memory (
    input  mem_we, mem_addr, mem_din,
    output mem_dout
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Two-master arbiter and sequencer for a single-port memory. Master 0 is the
// CPU path, master 1 a secondary requester (loader / debug / DMA). One access
// at a time runs through IDLE -> ACC -> RESP; read data is returned in a
// per-master register with a one-cycle ready pulse.
// Parameters:
//   ADDR_W  - word address width
//   DATA_W  - data width
//   MEM_LAT - cycles from address presented to mem_dout valid (1..3)
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mem_port_arbiter_if.slave: both requester ports, memory pins, owner
// Build option:
//   ARB_ROUND_ROBIN_EN - when defined, simultaneous requests alternate
//   between the masters; otherwise master 0 always wins.
module mem_port_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_M0   = 2'b01;
  localparam logic [1:0] OWN_M1   = 2'b10;
  localparam logic [1:0] LAST_CNT = 2'(MEM_LAT - 1);

  state_t state;
  state_t next_state;

  // Transaction latched at grant time
  logic              sel;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [1:0]        cnt;

  // Arbitration result
  logic              any_req;
  logic              grant_sel;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              acc_last;

  // Next values of the registered outputs
  logic              nxt_mem_we;
  logic [ADDR_W-1:0] nxt_mem_addr;
  logic [DATA_W-1:0] nxt_mem_din;
  logic [1:0]        nxt_owner;
  logic              nxt_m0_ready;
  logic              nxt_m1_ready;

  // Registered outputs
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;
  logic [1:0]        owner_q;
  logic              m0_ready_q;
  logic              m1_ready_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;

  assign any_req = bus.m0_req | bus.m1_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Most recently granted master; resetting to master 1 makes master 0 win
  // the first conflict.
  logic last;

  always_comb begin
    grant_sel = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      grant_sel = ~last;
    end else if (bus.m1_req) begin
      grant_sel = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last <= grant_sel;
    end
  end
`else
  // Master 1 only wins when master 0 is not asking.
  always_comb begin
    grant_sel = ~bus.m0_req & bus.m1_req;
  end
`endif

  always_comb begin
    g_we    = grant_sel ? bus.m1_we    : bus.m0_we;
    g_addr  = grant_sel ? bus.m1_addr  : bus.m0_addr;
    g_wdata = grant_sel ? bus.m1_wdata : bus.m0_wdata;
  end

  // Writes occupy a single ACC cycle whatever the memory latency is.
  assign acc_last = lat_we || (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Memory pins and ready flags are computed one cycle ahead and registered,
  // so nothing toward the memory is combinational from the request inputs.
  always_comb begin
    next_state   = state;
    nxt_mem_we   = 1'b0;
    nxt_mem_addr = '0;
    nxt_mem_din  = '0;
    nxt_owner    = OWN_NONE;
    nxt_m0_ready = 1'b0;
    nxt_m1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          next_state   = ACC;
          nxt_mem_we   = g_we;
          nxt_mem_addr = g_addr;
          nxt_mem_din  = g_we ? g_wdata : '0;
          nxt_owner    = grant_sel ? OWN_M1 : OWN_M0;
        end
      end
      ACC: begin
        nxt_owner = owner_q;
        if (acc_last) begin
          next_state   = RESP;
          nxt_m0_ready = ~sel;
          nxt_m1_ready = sel;
        end else begin
          // Only reads stay in ACC for more than one cycle.
          nxt_mem_addr = lat_addr;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      owner_q    <= OWN_NONE;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      sel        <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      cnt        <= '0;
    end else begin
      mem_we_q   <= nxt_mem_we;
      mem_addr_q <= nxt_mem_addr;
      mem_din_q  <= nxt_mem_din;
      owner_q    <= nxt_owner;
      m0_ready_q <= nxt_m0_ready;
      m1_ready_q <= nxt_m1_ready;
      if (state == IDLE && any_req) begin
        sel      <= grant_sel;
        lat_we   <= g_we;
        lat_addr <= g_addr;
        cnt      <= '0;
      end else if (state == ACC) begin
        cnt <= cnt + 2'd1;
        // mem_dout is valid on the last ACC edge of a read.
        if (acc_last && !lat_we) begin
          if (sel) begin
            m1_rdata_q <= bus.mem_dout;
          end else begin
            m0_rdata_q <= bus.mem_dout;
          end
        end
      end
    end
  end

  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.owner    = owner_q;
  assign bus.m0_ready = m0_ready_q;
  assign bus.m1_ready = m1_ready_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_rdata = m1_rdata_q;

endmodule
